// File: rtl/timer_ctrl_if.sv
// -----------------------------------------------------------------------------
// timer_ctrl_if
// Groups the button inputs, the time_up level and the count/clear/status
// outputs of the ramen timer control stage.
//   master : the environment side (drives buttons and time_up)
//   slave  : the timer_ctrl side (drives tick_rdy, clear_rdy, running, alarm)
// Signals:
//   btn_start  raw start/pause button, asynchronous, active-high
//   btn_clr    raw clear button, asynchronous, active-high
//   time_up    level from the digit chain, high when target time is reached
//   tick_rdy   one-cycle count pulse (also issued during a clear)
//   clear_rdy  high only together with tick_rdy during a clear
//   running    high while counting
//   alarm      high while the target time has been reached
// -----------------------------------------------------------------------------
interface timer_ctrl_if;
    logic btn_start;
    logic btn_clr;
    logic time_up;
    logic tick_rdy;
    logic clear_rdy;
    logic running;
    logic alarm;

    modport master (
        output btn_start,
        output btn_clr,
        output time_up,
        input  tick_rdy,
        input  clear_rdy,
        input  running,
        input  alarm
    );

    modport slave (
        input  btn_start,
        input  btn_clr,
        input  time_up,
        output tick_rdy,
        output clear_rdy,
        output running,
        output alarm
    );
endinterface

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
// Control stage in front of the digit counter chain of the ramen timer.
// Debounces the start/pause and clear buttons, runs the IDLE/RUN/PAUSE/DONE
// state machine, produces the one-second count pulse (tick_rdy) for the least
// significant digit and the clear qualifier (clear_rdy) for every digit.
// A clear is a single cycle with tick_rdy=1 and clear_rdy=1, which makes every
// digit load zero; tick_rdy alone means increment.
// Ports:
//   clk   single clock
//   rst   synchronous, active-high reset
//   bus   timer_ctrl_if.slave (buttons, time_up in; tick/clear/status out)
// Parameters:
//   TICK_DIV         clock cycles per count tick (>= 2)
//   DEBOUNCE_CYCLES  cycles a synced button level must stay stable (>= 1)
// -----------------------------------------------------------------------------
module timer_ctrl #(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic          clk,
    input  logic          rst,
    timer_ctrl_if.slave   bus
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PRESC_W = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0]   DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};

    // Index of each button inside the per-button vectors below.
    localparam int BTN_START = 0;
    localparam int BTN_CLR   = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // ---------------------------------------------------------------------
    // Button path: synchronizer, debouncer, rising-edge press detector
    // ---------------------------------------------------------------------
    logic [1:0]       raw_s;
    logic [1:0]       sync1_r;
    logic [1:0]       sync2_r;
    logic [1:0]       deb_r;
    logic [1:0]       deb_d_r;
    logic [1:0]       press_r;
    logic [CNT_W-1:0] deb_cnt_r [2];

    logic start_press_s;
    logic clr_press_s;

    assign raw_s[BTN_START] = bus.btn_start;
    assign raw_s[BTN_CLR]   = bus.btn_clr;

    // Synchronize, debounce and edge-detect both buttons with identical logic.
    // The press pulse is registered, so an event reaches the FSM one cycle
    // after the debounced level rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
            deb_r   <= 2'b00;
            deb_d_r <= 2'b00;
            press_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            deb_d_r <= deb_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    // Any agreeing cycle restarts the stability window.
                    deb_cnt_r[i] <= {CNT_W{1'b0}};
                end else if (deb_cnt_r[i] == DEB_LAST) begin
                    // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
                    deb_r[i]     <= sync2_r[i];
                    deb_cnt_r[i] <= {CNT_W{1'b0}};
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + CNT_W'(1);
                end
                // Only the 0->1 transition of the debounced level is an event.
                press_r[i] <= deb_r[i] & ~deb_d_r[i];
            end
        end
    end

    assign start_press_s = press_r[BTN_START];
    assign clr_press_s   = press_r[BTN_CLR];

    // ---------------------------------------------------------------------
    // State machine and prescaler
    // ---------------------------------------------------------------------
    state_t               state_r;
    state_t               state_next_s;
    logic [PRESC_W-1:0]   presc_r;
    logic [PRESC_W-1:0]   presc_next_s;
    logic                 tick_s;
    logic                 clear_s;

    logic                 tick_r;
    logic                 clear_r;
    logic                 running_r;
    logic                 alarm_r;

    // Next state, next prescaler value and the tick/clear requests.
    always_comb begin
        state_next_s = state_r;
        presc_next_s = presc_r;
        tick_s       = 1'b0;
        clear_s      = 1'b0;
        if (clr_press_s) begin
            // Clear wins over start and time_up in every state.
            state_next_s = IDLE;
            presc_next_s = PRESC_ZERO;
            clear_s      = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_press_s) begin
                        state_next_s = RUN;
                        presc_next_s = PRESC_ZERO;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                RUN: begin
                    if (bus.time_up) begin
                        // Target reached: stop, and swallow a coinciding tick.
                        state_next_s = DONE;
                        presc_next_s = PRESC_ZERO;
                    end else if (start_press_s) begin
                        // The pausing cycle is still a RUN cycle and counts
                        // toward the phase; a tick due in this very cycle is
                        // deferred by holding the terminal value.
                        state_next_s = PAUSE;
                        if (presc_r == PRESC_MAX) begin
                            presc_next_s = presc_r;
                        end else begin
                            presc_next_s = presc_r + PRESC_W'(1);
                        end
                    end else if (presc_r == PRESC_MAX) begin
                        tick_s       = 1'b1;
                        presc_next_s = PRESC_ZERO;
                    end else begin
                        presc_next_s = presc_r + PRESC_W'(1);
                    end
                end
                PAUSE: begin
                    // Prescaler keeps its value so the tick phase survives.
                    if (start_press_s) begin
                        state_next_s = RUN;
                    end else begin
                        state_next_s = PAUSE;
                    end
                end
                DONE: begin
                    if (start_press_s) begin
                        state_next_s = IDLE;
                        presc_next_s = PRESC_ZERO;
                        clear_s      = 1'b1;
                    end else begin
                        state_next_s = DONE;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                    presc_next_s = PRESC_ZERO;
                end
            endcase
        end
    end

    // State, prescaler and registered outputs; status outputs follow the
    // next state so they change on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            presc_r   <= PRESC_ZERO;
            tick_r    <= 1'b0;
            clear_r   <= 1'b0;
            running_r <= 1'b0;
            alarm_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            presc_r   <= presc_next_s;
            tick_r    <= tick_s | clear_s;
            clear_r   <= clear_s;
            running_r <= (state_next_s == RUN);
            alarm_r   <= (state_next_s == DONE);
        end
    end

    assign bus.tick_rdy  = tick_r;
    assign bus.clear_rdy = clear_r;
    assign bus.running   = running_r;
    assign bus.alarm     = alarm_r;

endmodule

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl
// Directed and randomized stimulus for timer_ctrl with TICK_DIV=10 and
// DEBOUNCE_CYCLES=4. A behavioural model predicts every output each cycle:
// button presses are turned into FSM events with the documented latency
// (first high sample at edge N acts at edge N+DEBOUNCE_CYCLES+3 when held
// for at least DEBOUNCE_CYCLES samples), and the run/pause/done rules are
// applied on a RUN-cycle phase count.
// -----------------------------------------------------------------------------
module tb_timer_ctrl;

    localparam int T    = 10;
    localparam int D    = 4;
    localparam int MAXC = 6000;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic rst;

    timer_ctrl_if bus ();

    timer_ctrl #(.TICK_DIV(T), .DEBOUNCE_CYCLES(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int  errors = 0;
    int  checks = 0;
    int  cyc    = 0;
    bit  start_ev [MAXC];
    bit  clr_ev   [MAXC];

    int  m_state  = M_IDLE;
    int  m_phase  = 0;
    bit  m_tick   = 1'b0;
    bit  m_clear  = 1'b0;

    int  tu_mode  = 0;
    int  run_rise = -1;
    int  tick_q[$];

    task automatic check(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: got %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Apply one clock edge of the specified behaviour to the model.
    task automatic model_edge();
        bit s;
        bit c;
        bit tu;
        s  = start_ev[cyc];
        c  = clr_ev[cyc];
        tu = bus.time_up;
        m_tick  = 1'b0;
        m_clear = 1'b0;
        if (rst) begin
            m_state = M_IDLE;
            m_phase = 0;
        end else if (c) begin
            m_state = M_IDLE;
            m_phase = 0;
            m_tick  = 1'b1;
            m_clear = 1'b1;
        end else begin
            case (m_state)
                M_IDLE: if (s) begin m_state = M_RUN; m_phase = 0; end
                M_RUN: begin
                    if (tu) begin
                        m_state = M_DONE;
                        m_phase = 0;
                    end else if (s) begin
                        m_state = M_PAUSE;
                        m_phase = (m_phase + 1 < T) ? m_phase + 1 : m_phase;
                    end else begin
                        m_phase = m_phase + 1;
                        if (m_phase == T) begin
                            m_tick  = 1'b1;
                            m_phase = 0;
                        end
                    end
                end
                M_PAUSE: if (s) m_state = M_RUN;
                M_DONE: if (s) begin
                    m_state = M_IDLE;
                    m_phase = 0;
                    m_tick  = 1'b1;
                    m_clear = 1'b1;
                end
                default: m_state = M_IDLE;
            endcase
        end
    endtask

    // One clock: choose time_up, advance model, compare all outputs.
    task automatic step();
        if (tu_mode == 1)
            bus.time_up = (m_state == M_RUN) && (m_phase == T - 1);
        else if (tu_mode == 2)
            bus.time_up = (m_state == M_RUN) && ($urandom_range(0, 15) == 0);
        else
            bus.time_up = 1'b0;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("tick_rdy",  bus.tick_rdy,  m_tick);
        check("clear_rdy", bus.clear_rdy, m_clear);
        check("running",   bus.running,   m_state == M_RUN);
        check("alarm",     bus.alarm,     m_state == M_DONE);
        if (bus.running === 1'b1 && run_rise < 0) run_rise = cyc;
        if (bus.tick_rdy === 1'b1 && bus.clear_rdy === 1'b0) tick_q.push_back(cyc);
    endtask

    // Hold the chosen buttons high for len samples, then low for gap cycles.
    task automatic press(bit do_s, bit do_c, int len, int gap);
        int n;
        n = cyc + 1;
        if (len >= D && n + D + 3 < MAXC) begin
            if (do_s) start_ev[n + D + 3] = 1'b1;
            if (do_c) clr_ev[n + D + 3]   = 1'b1;
        end
        bus.btn_start = do_s;
        bus.btn_clr   = do_c;
        repeat (len) step();
        bus.btn_start = 1'b0;
        bus.btn_clr   = 1'b0;
        repeat (gap) step();
    endtask

    initial begin
        int n0;
        int a;
        int k;
        rst           = 1'b1;
        bus.btn_start = 1'b0;
        bus.btn_clr   = 1'b0;
        bus.time_up   = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // 1. start, latency and tick period
        run_rise = -1;
        tick_q.delete();
        n0 = cyc + 1;
        press(1'b1, 1'b0, 20, 15);
        check_int("start_latency", run_rise, n0 + 7);
        check_int("first_tick",  (tick_q.size() > 0) ? tick_q[0] : -1, n0 + 17);
        check_int("second_tick", (tick_q.size() > 1) ? tick_q[1] : -1, n0 + 27);

        // 2. clear, then glitch rejection
        press(1'b0, 1'b1, 6, 12);
        run_rise = -1;
        repeat (5) press(1'b1, 1'b0, 3, 10);
        check_int("glitch_no_run", run_rise, -1);

        // 3. pause four RUN cycles after a tick, then resume
        press(1'b1, 1'b0, 6, 10);
        for (k = 0; k < 40 && !(m_state == M_RUN && m_phase == T - 4); k++) step();
        press(1'b1, 1'b0, 6, 8);
        tick_q.delete();
        repeat (30) step();
        check_int("pause_no_ticks", tick_q.size(), 0);
        run_rise = -1;
        press(1'b1, 1'b0, 6, 12);
        check_int("resume_phase", (tick_q.size() > 0) ? tick_q[0] - run_rise : -1, 6);

        // 4. time_up on the would-be tick, then start clears from DONE
        tu_mode = 1;
        for (k = 0; k < 40 && m_state != M_DONE; k++) step();
        tu_mode = 0;
        repeat (5) step();
        press(1'b1, 1'b0, 6, 10);

        // 5. simultaneous start and clear from RUN, PAUSE and DONE
        press(1'b1, 1'b0, 6, 13);
        press(1'b1, 1'b1, 6, 10);
        press(1'b1, 1'b0, 6, 10);
        press(1'b1, 1'b0, 5, 12);
        press(1'b1, 1'b1, 7, 10);
        press(1'b1, 1'b0, 6, 10);
        tu_mode = 1;
        for (k = 0; k < 40 && m_state != M_DONE; k++) step();
        tu_mode = 0;
        press(1'b1, 1'b1, 6, 10);

        // 6. reset mid-run with the prescaler at 5
        press(1'b1, 1'b0, 6, 10);
        for (k = 0; k < 40 && !(m_state == M_RUN && m_phase == 5); k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();
        run_rise = -1;
        tick_q.delete();
        press(1'b1, 1'b0, 6, 20);
        check_int("post_reset_tick", (tick_q.size() > 0) ? tick_q[0] - run_rise : -1, 10);

        // Randomized mix of presses, glitches, waits and time_up
        for (int it = 0; it < 30; it++) begin
            a = $urandom_range(0, 6);
            tu_mode = ($urandom_range(0, 2) == 0) ? 2 : 0;
            case (a)
                0, 1: press(1'b1, 1'b0, $urandom_range(D, D + 6), $urandom_range(D + 4, D + 20));
                2:    press(1'b0, 1'b1, $urandom_range(D, D + 6), $urandom_range(D + 4, D + 20));
                3:    press(1'b1, 1'b0, $urandom_range(1, D - 1), $urandom_range(D + 4, D + 12));
                4:    press(1'b0, 1'b1, $urandom_range(1, D - 1), $urandom_range(D + 4, D + 12));
                5:    press(1'b1, 1'b1, $urandom_range(D, D + 6), $urandom_range(D + 4, D + 20));
                default: repeat ($urandom_range(5, 40)) step();
            endcase
        end
        tu_mode = 0;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
